// File: rtl/scroll_lineas_if.sv
// Bundle between the centre-line scroll generator and its video/sprite/control neighbours.
interface scroll_lineas_if #(
    parameter int NUM_DASH = 3
);
    logic                    enable;
    logic [9:0]              hcount;
    logic [9:0]              vcount;
    logic [3:0]              target_speed;
    logic                    crash;
    logic [9:0]              posx;
    logic [10*NUM_DASH-1:0]  posy_bus;
    logic [3:0]              speed;
    logic                    frame_tick;
    logic [15:0]             distance;

    modport master (
        output enable, hcount, vcount, target_speed, crash,
        input  posx, posy_bus, speed, frame_tick, distance
    );

    modport slave (
        input  enable, hcount, vcount, target_speed, crash,
        output posx, posy_bus, speed, frame_tick, distance
    );
endinterface

// File: rtl/scroll_lineas.sv
// Per-frame scroll offset, speed ramp and crash stop for the centre-dash sprites.
// Optional odometer accumulator is built only when ODOMETER_EN is defined.
module scroll_lineas #(
    parameter int NUM_DASH     = 3,
    parameter int DASH_PERIOD  = 160,
    parameter int POSX         = 307,
    parameter int FRAME_LINE   = 480,
    parameter int MAX_SPEED    = 15,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    scroll_lineas_if.slave   bus
);
    localparam int              CNT_W     = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
    localparam logic [9:0]      FRAME_V   = 10'(FRAME_LINE);
    localparam logic [9:0]      POSX_V    = 10'(POSX);
    localparam logic [10:0]     PERIOD_V  = 11'(DASH_PERIOD);
    localparam logic [3:0]      MAX_V     = 4'(MAX_SPEED);

    typedef enum logic [0:0] {HOLD = 1'b0, RAMP = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [9:0]           offset_q, offset_d;
    logic [3:0]           speed_q, speed_d;
    logic [CNT_W-1:0]     accel_cnt_q, accel_cnt_d;
    logic                 match_s, match_q;
    logic                 frame_tick_q, frame_tick_d;
    logic                 upd_s;
    logic [10:0]          sum_s;
    logic [3:0]           tgt_s;
    logic [10*NUM_DASH-1:0] posy_s;

    // Rising edge of the frame point; match_q keeps tracking while frozen
    always_comb begin
        match_s      = (bus.hcount == 10'd0) && (bus.vcount == FRAME_V);
        frame_tick_d = match_s & ~match_q & bus.enable;
        upd_s        = frame_tick_q & bus.enable;
    end

    // Offset wraps modulo the dash pitch; the sum is one bit wider than the offset
    always_comb begin
        sum_s = {1'b0, offset_q} + {7'd0, speed_q};
        if (upd_s) begin
            if (sum_s >= PERIOD_V) begin
                offset_d = 10'(sum_s - PERIOD_V);
            end else begin
                offset_d = sum_s[9:0];
            end
        end else begin
            offset_d = offset_q;
        end
    end

    // Speed FSM: crash wins, otherwise step one unit every ACCEL_FRAMES ticks
    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        accel_cnt_d = accel_cnt_q;
        if (bus.target_speed > MAX_V) begin
            tgt_s = MAX_V;
        end else begin
            tgt_s = bus.target_speed;
        end
        if (upd_s) begin
            if (bus.crash) begin
                speed_d     = 4'd0;
                accel_cnt_d = '0;
                state_d     = HOLD;
            end else if (speed_q == tgt_s) begin
                accel_cnt_d = '0;
                state_d     = HOLD;
            end else begin
                state_d = RAMP;
                if (accel_cnt_q == CNT_LAST) begin
                    accel_cnt_d = '0;
                    if (speed_q < tgt_s) begin
                        speed_d = speed_q + 4'd1;
                    end else begin
                        speed_d = speed_q - 4'd1;
                    end
                end else begin
                    accel_cnt_d = accel_cnt_q + CNT_W'(1);
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // Dash slots are fixed pitch apart; the pitch limits keep every slot inside 10 bits
    always_comb begin
        posy_s = '0;
        for (int i = 0; i < NUM_DASH; i++) begin
            posy_s[10*i +: 10] = offset_q + 10'(i * DASH_PERIOD);
        end
    end

    // Scroll and speed state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HOLD;
            offset_q     <= 10'd0;
            speed_q      <= 4'd0;
            accel_cnt_q  <= '0;
            match_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            speed_q      <= speed_d;
            accel_cnt_q  <= accel_cnt_d;
            match_q      <= match_s;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef ODOMETER_EN
    logic [15:0] distance_q, distance_d;
    logic [16:0] dist_sum_s;

    // Odometer saturates rather than wrapping
    always_comb begin
        dist_sum_s = {1'b0, distance_q} + {13'd0, speed_q};
        if (upd_s) begin
            if (dist_sum_s[16]) begin
                distance_d = 16'hFFFF;
            end else begin
                distance_d = dist_sum_s[15:0];
            end
        end else begin
            distance_d = distance_q;
        end
    end

    // Odometer register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            distance_q <= 16'h0000;
        end else begin
            distance_q <= distance_d;
        end
    end

    assign bus.distance = distance_q;
`else
    assign bus.distance = 16'h0000;
`endif

    assign bus.posx       = POSX_V;
    assign bus.posy_bus   = posy_s;
    assign bus.speed      = speed_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_scroll_lineas.sv
// Directed bench for scroll_lineas: reset, frame detect, ramp, wrap, crash, freeze, async reset, odometer.
module tb_scroll_lineas;
    logic clock;
    logic reset_n;
    int   pass_cnt;
    int   total_cnt;

    scroll_lineas_if #(.NUM_DASH(3)) bus ();

    scroll_lineas dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset;
        @(negedge clock);
        reset_n          = 1'b0;
        bus.enable       = 1'b1;
        bus.hcount       = 10'd5;
        bus.vcount       = 10'd0;
        bus.target_speed = 4'd0;
        bus.crash        = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // One frame event: frame point held for 'hold' cycles, then one idle cycle.
    task automatic frame(input int hold);
        bus.hcount = 10'd0;
        bus.vcount = 10'd480;
        repeat (hold) @(negedge clock);
        bus.vcount = 10'd0;
        @(negedge clock);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        chk("reset_slot0", int'(bus.posy_bus[9:0]), 0);
        chk("reset_slot1", int'(bus.posy_bus[19:10]), 160);
        chk("reset_slot2", int'(bus.posy_bus[29:20]), 320);
        chk("reset_posx", int'(bus.posx), 307);
        chk("reset_speed", int'(bus.speed), 0);
        chk("reset_tick", int'(bus.frame_tick), 0);
        chk("reset_distance", int'(bus.distance), 0);
    endtask

    task automatic count_ticks(input int hold, output int ticks);
        ticks = 0;
        bus.hcount = 10'd0;
        bus.vcount = 10'd480;
        for (int c = 0; c < hold + 3; c++) begin
            @(negedge clock);
            if (bus.frame_tick === 1'b1) ticks++;
            if (c == hold - 1) bus.vcount = 10'd0;
        end
    endtask

    task automatic test_frame_detect;
        int ticks;
        do_reset();
        count_ticks(2, ticks);
        chk("tick_held2", ticks, 1);
        count_ticks(3, ticks);
        chk("tick_held3", ticks, 1);
        bus.enable = 1'b0;
        count_ticks(2, ticks);
        chk("tick_disabled", ticks, 0);
        bus.enable = 1'b1;
        // Frame point while hcount is nonzero is not a frame point
        bus.hcount = 10'd1;
        bus.vcount = 10'd480;
        ticks = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.frame_tick === 1'b1) ticks++;
        end
        chk("tick_hcount_nz", ticks, 0);
        // Enable rises while the frame point is already present
        bus.vcount = 10'd0;
        @(negedge clock);
        bus.enable = 1'b0;
        bus.hcount = 10'd0;
        bus.vcount = 10'd480;
        ticks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (bus.frame_tick === 1'b1) ticks++;
            if (c == 1) bus.enable = 1'b1;
        end
        bus.vcount = 10'd0;
        @(negedge clock);
        chk("tick_reenable_no_spurious", ticks, 0);
    endtask

    task automatic test_ramp;
        int spd_tbl [14] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3};
        int off_tbl [14] = '{0, 0, 0, 0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18};
        do_reset();
        bus.target_speed = 4'd3;
        for (int k = 0; k < 14; k++) begin
            frame(2);
            chk($sformatf("ramp_speed_t%0d", k + 1), int'(bus.speed), spd_tbl[k]);
            chk($sformatf("ramp_offset_t%0d", k + 1), int'(bus.posy_bus[9:0]), off_tbl[k]);
        end
    endtask

    task automatic test_clamp;
        do_reset();
        bus.target_speed = 4'd15;
        repeat (4) frame(1);
        chk("clamp_step1", int'(bus.speed), 1);
    endtask

    task automatic test_wrap;
        do_reset();
        bus.target_speed = 4'd1;
        repeat (4 + 134) frame(1);
        chk("wrap_pre_speed1", int'(bus.speed), 1);
        chk("wrap_pre_offset134", int'(bus.posy_bus[9:0]), 134);
        bus.target_speed = 4'd4;
        repeat (12) frame(1);
        chk("wrap_speed4", int'(bus.speed), 4);
        chk("wrap_offset158", int'(bus.posy_bus[9:0]), 158);
        frame(1);
        chk("wrap_slot0", int'(bus.posy_bus[9:0]), 2);
        chk("wrap_slot1", int'(bus.posy_bus[19:10]), 162);
        chk("wrap_slot2", int'(bus.posy_bus[29:20]), 322);
        chk("wrap_speed_hold", int'(bus.speed), 4);
    endtask

    task automatic test_crash;
        do_reset();
        bus.target_speed = 4'd9;
        repeat (20) frame(1);
        chk("crash_pre_speed5", int'(bus.speed), 5);
        chk("crash_pre_offset40", int'(bus.posy_bus[9:0]), 40);
        frame(1);
        chk("crash_midramp_offset45", int'(bus.posy_bus[9:0]), 45);
        bus.crash = 1'b1;
        frame(1);
        chk("crash_speed0", int'(bus.speed), 0);
        chk("crash_offset50", int'(bus.posy_bus[9:0]), 50);
        frame(1);
        chk("crash_held_speed0", int'(bus.speed), 0);
        bus.crash = 1'b0;
        repeat (3) frame(1);
        chk("crash_cnt_cleared", int'(bus.speed), 0);
        frame(1);
        chk("crash_restart_speed1", int'(bus.speed), 1);
        chk("crash_restart_offset", int'(bus.posy_bus[9:0]), 50);
        bus.enable = 1'b0;
        repeat (2) frame(1);
        chk("freeze_offset", int'(bus.posy_bus[9:0]), 50);
        chk("freeze_speed", int'(bus.speed), 1);
        bus.enable = 1'b1;
        frame(1);
        chk("unfreeze_offset51", int'(bus.posy_bus[9:0]), 51);
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.target_speed = 4'd6;
        repeat (10) frame(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_slot0", int'(bus.posy_bus[9:0]), 0);
        chk("async_slot1", int'(bus.posy_bus[19:10]), 160);
        chk("async_speed", int'(bus.speed), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_odometer;
        do_reset();
        bus.target_speed = 4'd5;
`ifdef ODOMETER_EN
        repeat (20) frame(1);
        chk("odo_after_ramp", int'(bus.distance), 40);
        repeat (13099) frame(1);
        chk("odo_reach_max", int'(bus.distance), 65535);
        repeat (3) frame(1);
        chk("odo_saturated", int'(bus.distance), 65535);
`else
        repeat (24) frame(1);
        chk("odo_disabled_zero", int'(bus.distance), 0);
        chk("odo_disabled_speed", int'(bus.speed), 5);
`endif
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        reset_n          = 1'b0;
        bus.enable       = 1'b0;
        bus.hcount       = 10'd0;
        bus.vcount       = 10'd0;
        bus.target_speed = 4'd0;
        bus.crash        = 1'b0;
        test_reset();
        test_frame_detect();
        test_ramp();
        test_clamp();
        test_wrap();
        test_crash();
        test_async_reset();
        test_odometer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
